// File: rtl/hc02_selftest.sv
// rtl/hc02_selftest.sv - built-in self-test sequencer for a quad 2-input NOR gate emulation
module hc02_selftest #(
    parameter int NUM_GATES = 4,
    parameter int SETTLE    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_GATES-1:0] gate_y,
    output logic [NUM_GATES-1:0] gate_a,
    output logic [NUM_GATES-1:0] gate_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask
);

    if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
        $error("hc02_selftest: SETTLE must be in 2..15");
    end
    if (NUM_GATES < 1 || NUM_GATES > 8) begin : g_bad_gates
        $error("hc02_selftest: NUM_GATES must be in 1..8");
    end

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           vec;
    logic [3:0]           cnt;
    logic [NUM_GATES-1:0] y_m;
    logic [NUM_GATES-1:0] y_s;
    logic                 cmp_valid;
    logic                 cmp_exp;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] fail_acc;

    // The compare is taken one edge after the settle countdown expires, so the
    // synchronized sample it reads was launched by the vector being checked
    // rather than by the previous one. The last compare lands on the DONE edge
    // and is folded into pass combinationally.
    assign mism     = cmp_valid ? (y_s ^ {NUM_GATES{cmp_exp}}) : '0;
    assign fail_acc = fail_mask | mism;

    // Next-state logic for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (abort)                          state_nxt = IDLE;
                else if (cnt == 4'd0 && vec == 2'd3) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Two-flop synchronizer on the asynchronous gate outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_m <= '0;
            y_s <= '0;
        end else begin
            y_m <= gate_y;
            y_s <= y_m;
        end
    end

    // Vector index, settle countdown and compare scheduling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= 2'd0;
            cnt       <= 4'd0;
            cmp_valid <= 1'b0;
            cmp_exp   <= 1'b0;
        end else begin
            cmp_valid <= 1'b0;
            if (state == IDLE && start) begin
                vec <= 2'd0;
                cnt <= SETTLE_CNT;
            end else if (state == RUN && !abort) begin
                if (cnt == 4'd0) begin
                    cmp_valid <= 1'b1;
                    cmp_exp   <= (vec == 2'd0);
                    if (vec != 2'd3) begin
                        vec <= vec + 2'd1;
                        cnt <= SETTLE_CNT;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    // Result accumulation: cleared on an accepted start, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_mask <= '0;
            pass      <= 1'b0;
        end else if (state == IDLE && start) begin
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            fail_mask <= fail_acc;
            if (state == DONE)              pass <= (fail_acc == '0);
            else if (state == RUN && abort) pass <= 1'b0;
        end
    end

    // Registered pad drive and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_a <= '0;
            gate_b <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            gate_a <= (state == RUN) ? {NUM_GATES{vec[1]}} : '0;
            gate_b <= (state == RUN) ? {NUM_GATES{vec[0]}} : '0;
            busy   <= (state == RUN);
            done   <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_hc02_selftest.sv
// tb/tb_hc02_selftest.sv - directed self-checking bench for hc02_selftest
module tb_hc02_selftest;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;

    logic [3:0] gate_y;
    logic [3:0] gate_a;
    logic [3:0] gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;

    logic [0:0] gate_y2 = 1'b1;
    logic [0:0] gate_a2;
    logic [0:0] gate_b2;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [0:0] fail_mask2;

    // 0 = healthy NOR, 1 = stuck-at-1, 2 = stuck-at-0, 3 = wired as OR
    logic [1:0] mode [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hc02_selftest #(.NUM_GATES(4), .SETTLE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_y(gate_y), .gate_a(gate_a), .gate_b(gate_b),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    hc02_selftest #(.NUM_GATES(1), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .gate_y(gate_y2), .gate_a(gate_a2), .gate_b(gate_b2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2)
    );

    // Gate model for the 4-gate build
    always_comb begin
        gate_y = '0;
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                2'd0:    gate_y[i] = ~(gate_a[i] | gate_b[i]);
                2'd1:    gate_y[i] = 1'b1;
                2'd2:    gate_y[i] = 1'b0;
                default: gate_y[i] = gate_a[i] | gate_b[i];
            endcase
        end
    end

    // Slow NOR for the 1-gate build: output follows inputs most of a cycle later
    always begin
        @(gate_a2 or gate_b2);
        #8;
        gate_y2 = ~(gate_a2 | gate_b2);
    end

    task automatic set_modes(input logic [1:0] m0, input logic [1:0] m1,
                             input logic [1:0] m2, input logic [1:0] m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    endtask

    // One full run of the 4-gate build from a start pulse, with inline checks
    task automatic do_run(input bit chk_vec, input logic [3:0] exp_mask,
                          input logic exp_pass, input string name);
        int done_cnt;
        int done_at;
        logic [3:0] kv;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (chk_vec && (c == 1 || c == 5 || c == 9 || c == 13)) begin
                kv = 4'((c - 1) / 4);
                checks++;
                if (gate_a !== {4{kv[1]}} || gate_b !== {4{kv[0]}}) begin
                    errors++;
                    $display("FAIL %s vec@T0+%0d: a=%b b=%b expected a=%b b=%b",
                             name, c, gate_a, gate_b, {4{kv[1]}}, {4{kv[0]}});
                end
            end
            if (chk_vec && c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy@T0+1: got %b expected 1", name, busy);
                end
            end
            if (c == 17) begin
                checks++;
                if (pass !== exp_pass || fail_mask !== exp_mask || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s result@T0+17: pass=%b mask=%b busy=%b expected pass=%b mask=%b busy=0",
                             name, pass, fail_mask, busy, exp_pass, exp_mask);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 17) begin
            errors++;
            $display("FAIL %s done: count=%0d at=%0d expected count=1 at=17", name, done_cnt, done_at);
        end
    endtask

    task automatic test_reset();
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gate_a !== 4'd0 || gate_b !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || fail_mask !== 4'd0) begin
            errors++;
            $display("FAIL reset: a=%b b=%b busy=%b done=%b pass=%b mask=%b expected all 0",
                     gate_a, gate_b, busy, done, pass, fail_mask);
        end
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || pass2 !== 1'b0 || fail_mask2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: busy=%b done=%b pass=%b mask=%b expected all 0",
                     busy2, done2, pass2, fail_mask2);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_healthy();
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        do_run(1'b1, 4'b0000, 1'b1, "healthy");
    endtask

    task automatic test_stuck1();
        set_modes(2'd0, 2'd0, 2'd1, 2'd0);
        do_run(1'b0, 4'b0100, 1'b0, "stuck1_g2");
    endtask

    task automatic test_or_stuck0();
        set_modes(2'd3, 2'd0, 2'd0, 2'd2);
        do_run(1'b0, 4'b1001, 1'b0, "or_g0_stuck0_g3");
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        do_run(1'b0, 4'b0000, 1'b1, "healthy_after_fail");
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int first_at;
        int second_at;
        done_cnt  = 0;
        first_at  = -1;
        second_at = -1;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk) start = (c == 5 || c == 17 || c == 18);
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_at < 0) first_at = c;
                else              second_at = c;
            end
        end
        start = 1'b0;
        checks++;
        if (done_cnt !== 2 || first_at !== 17 || second_at !== 35) begin
            errors++;
            $display("FAIL back_to_back: dones=%0d at %0d,%0d expected 2 at 17,35",
                     done_cnt, first_at, second_at);
        end
        checks++;
        if (pass !== 1'b1 || fail_mask !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back_result: pass=%b mask=%b expected pass=1 mask=0000",
                     pass, fail_mask);
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        set_modes(2'd2, 2'd0, 2'd0, 2'd0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk) begin
                start = 1'b0;
                abort = (c == 7);
            end
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (c == 7) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_busy@T0+7: got %b expected 1", busy);
                end
            end
            if (c == 8) begin
                checks++;
                if (busy !== 1'b0 || gate_a !== 4'd0 || gate_b !== 4'd0) begin
                    errors++;
                    $display("FAIL abort@T0+8: busy=%b a=%b b=%b expected 0 0000 0000",
                             busy, gate_a, gate_b);
                end
            end
        end
        abort = 1'b0;
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
        end
        checks++;
        if (pass !== 1'b0 || fail_mask !== 4'b0001) begin
            errors++;
            $display("FAIL abort_result: pass=%b mask=%b expected pass=0 mask=0001", pass, fail_mask);
        end
    endtask

    task automatic test_start_abort();
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        @(negedge clk) begin
            start = 1'b1;
            abort = 1'b1;
        end
        @(posedge clk);
        @(negedge clk) begin
            start = 1'b0;
            abort = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_abort: busy=%b expected 1", busy);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_beats_abort_result: pass=%b busy=%b expected 1 0", pass, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int done_cnt;
        done_cnt = 0;
        set_modes(2'd2, 2'd0, 2'd0, 2'd0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || fail_mask !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset@T0+10: busy=%b mask=%b expected 1 0001", busy, fail_mask);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || gate_a !== 4'd0 || gate_b !== 4'd0 || done !== 1'b0 ||
            pass !== 1'b0 || fail_mask !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b a=%b b=%b done=%b pass=%b mask=%b expected all 0",
                     busy, gate_a, gate_b, done, pass, fail_mask);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_resume: saw %0d busy/done cycles expected 0", done_cnt);
        end
    endtask

    task automatic test_small_build();
        int done_cnt;
        int done_at;
        logic [3:0] kv;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                done_cnt++;
                done_at = c;
            end
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                kv = 4'((c - 1) / 3);
                checks++;
                if (gate_a2 !== kv[1] || gate_b2 !== kv[0]) begin
                    errors++;
                    $display("FAIL small_vec@T0+%0d: a=%b b=%b expected a=%b b=%b",
                             c, gate_a2, gate_b2, kv[1], kv[0]);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 13) begin
            errors++;
            $display("FAIL small_done: count=%0d at=%0d expected count=1 at=13", done_cnt, done_at);
        end
        checks++;
        if (pass2 !== 1'b1 || fail_mask2 !== 1'b0) begin
            errors++;
            $display("FAIL small_result: pass=%b mask=%b expected pass=1 mask=0", pass2, fail_mask2);
        end
    endtask

    initial begin
        test_reset();
        test_healthy();
        test_stuck1();
        test_or_stuck0();
        test_back_to_back();
        test_abort();
        test_start_abort();
        test_reset_midrun();
        test_small_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
